frame_buffer_scheduler: RTL and testbench

// Allocates NUM_BUFFERS fixed DDR frame regions between the camera write path and the frame readout path.

---
 rtl/frame_buffer_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_frame_buffer_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_scheduler.sv
// Frame buffer scheduler: hands DDR frame regions to the camera writer, queues
// completed frames oldest-first and grants them to the readout engine. When
// no region is free the writer recycles the oldest unread frame.
module frame_buffer_scheduler #(
  parameter int          NUM_BUFFERS = 4,
  parameter logic [29:0] BUF_BASE    = 30'h0000_0000,
  parameter logic [29:0] BUF_STRIDE  = 30'h0080_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_frame_done,
  output logic [29:0] wr_start_addr,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [29:0] rd_addr,
  input  logic        rd_done,
  output logic        rd_busy,
  output logic [3:0]  ready_count,
  output logic [15:0] frames_dropped,
  output logic        protocol_err
);

  localparam int IW = $clog2(NUM_BUFFERS);

  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_state_e;

  // Start address of buffer idx, wrapped to the 30-bit DDR byte space.
  function automatic logic [29:0] buf_addr(input idx_t idx);
    logic [29:0] idx_w;
    idx_w = 30'(idx);
    return BUF_BASE + idx_w * BUF_STRIDE;
  endfunction

  buf_state_e  st_q    [NUM_BUFFERS];
  buf_state_e  st_d    [NUM_BUFFERS];
  logic [7:0]  stamp_q [NUM_BUFFERS];
  logic [7:0]  stamp_d [NUM_BUFFERS];
  logic [7:0]  seq_q, seq_d;
  idx_t        wr_idx_q, wr_idx_d;
  idx_t        rd_idx_q, rd_idx_d;
  logic [29:0] wr_addr_q, wr_addr_d;
  logic [29:0] rd_addr_q, rd_addr_d;
  logic        rd_ack_q, rd_ack_d;
  logic        rd_busy_q, rd_busy_d;
  logic [3:0]  ready_cnt_q, ready_cnt_d;
  logic [15:0] dropped_q, dropped_d;
  logic        perr_q, perr_d;

  logic        release_s;
  logic        grant_s;
  logic        gnt_found_s;
  idx_t        gnt_idx_s;
  logic [7:0]  gnt_age_s;
  logic [7:0]  gnt_cur_age_s;
  logic        gnt_pick_s;
  logic        rcy_found_s;
  idx_t        rcy_idx_s;
  logic [7:0]  rcy_age_s;
  logic [7:0]  rcy_cur_age_s;
  logic        rcy_pick_s;
  logic        free_found_s;
  idx_t        free_idx_s;
  logic        free_pick_s;
  idx_t        new_wr_s;

  assign release_s = rd_done & rd_busy_q;

  // Reader candidate: oldest READY buffer as it stood before this cycle's write completes.
  always_comb begin
    gnt_found_s   = 1'b0;
    gnt_idx_s     = '0;
    gnt_age_s     = 8'h00;
    gnt_cur_age_s = 8'h00;
    gnt_pick_s    = 1'b0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      gnt_cur_age_s = stamp_q[i] - seq_q;
      gnt_pick_s    = (st_q[i] == BUF_READY) && (!gnt_found_s || (gnt_cur_age_s < gnt_age_s));
      gnt_idx_s     = gnt_pick_s ? idx_t'(i) : gnt_idx_s;
      gnt_age_s     = gnt_pick_s ? gnt_cur_age_s : gnt_age_s;
      gnt_found_s   = gnt_found_s | gnt_pick_s;
    end
  end

  // Grant needs a waiting request, no reader holding a buffer after release, and no ack this cycle.
  assign grant_s = rd_req & ~rd_ack_q & (~rd_busy_q | rd_done) & gnt_found_s;

  // Recycle candidate: oldest READY buffer excluding the one the reader is taking.
  always_comb begin
    rcy_found_s   = 1'b0;
    rcy_idx_s     = '0;
    rcy_age_s     = 8'h00;
    rcy_cur_age_s = 8'h00;
    rcy_pick_s    = 1'b0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      rcy_cur_age_s = stamp_q[i] - seq_q;
      rcy_pick_s    = (st_q[i] == BUF_READY) &&
                      !(grant_s && (gnt_idx_s == idx_t'(i))) &&
                      (!rcy_found_s || (rcy_cur_age_s < rcy_age_s));
      rcy_idx_s     = rcy_pick_s ? idx_t'(i) : rcy_idx_s;
      rcy_age_s     = rcy_pick_s ? rcy_cur_age_s : rcy_age_s;
      rcy_found_s   = rcy_found_s | rcy_pick_s;
    end
  end

  // Lowest-index FREE buffer, counting a buffer the reader releases this cycle.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    free_pick_s  = 1'b0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      free_pick_s  = (st_q[i] == BUF_FREE) || (release_s && (rd_idx_q == idx_t'(i)));
      free_idx_s   = free_pick_s ? idx_t'(i) : free_idx_s;
      free_found_s = free_found_s | free_pick_s;
    end
  end

  // Next-state: release, then write completion, then read grant, then READY count.
  always_comb begin
    st_d        = st_q;
    stamp_d     = stamp_q;
    seq_d       = seq_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_ack_d    = 1'b0;
    rd_busy_d   = rd_busy_q;
    dropped_d   = dropped_q;
    perr_d      = perr_q;
    new_wr_s    = wr_idx_q;
    ready_cnt_d = 4'd0;

    if (rd_done) begin
      if (rd_busy_q) begin
        st_d[rd_idx_q] = BUF_FREE;
        rd_busy_d      = 1'b0;
      end else begin
        perr_d = 1'b1;
      end
    end else begin
      perr_d = perr_q;
    end

    if (wr_frame_done) begin
      st_d[wr_idx_q]    = BUF_READY;
      stamp_d[wr_idx_q] = seq_q;
      seq_d             = seq_q + 8'd1;
      if (free_found_s) begin
        new_wr_s = free_idx_s;
      end else begin
        new_wr_s  = rcy_idx_s;
        dropped_d = (dropped_q != 16'hFFFF) ? (dropped_q + 16'd1) : dropped_q;
      end
      st_d[new_wr_s] = BUF_WRITING;
      wr_idx_d       = new_wr_s;
      wr_addr_d      = buf_addr(new_wr_s);
    end else begin
      wr_idx_d = wr_idx_q;
    end

    if (grant_s) begin
      st_d[gnt_idx_s] = BUF_READING;
      rd_idx_d        = gnt_idx_s;
      rd_busy_d       = 1'b1;
      rd_ack_d        = 1'b1;
      rd_addr_d       = buf_addr(gnt_idx_s);
    end else begin
      rd_ack_d = 1'b0;
    end

    for (int i = 0; i < NUM_BUFFERS; i++) begin
      ready_cnt_d = ready_cnt_d + ((st_d[i] == BUF_READY) ? 4'd1 : 4'd0);
    end
  end

  // State register; reset hands buffer 0 to the writer and discards all frames.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        st_q[i]    <= (i == 0) ? BUF_WRITING : BUF_FREE;
        stamp_q[i] <= 8'h00;
      end
      seq_q       <= 8'h00;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      wr_addr_q   <= BUF_BASE;
      rd_addr_q   <= 30'h0000_0000;
      rd_ack_q    <= 1'b0;
      rd_busy_q   <= 1'b0;
      ready_cnt_q <= 4'd0;
      dropped_q   <= 16'h0000;
      perr_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      stamp_q     <= stamp_d;
      seq_q       <= seq_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_ack_q    <= rd_ack_d;
      rd_busy_q   <= rd_busy_d;
      ready_cnt_q <= ready_cnt_d;
      dropped_q   <= dropped_d;
      perr_q      <= perr_d;
    end
  end

  assign wr_start_addr  = wr_addr_q;
  assign rd_ack         = rd_ack_q;
  assign rd_addr        = rd_addr_q;
  assign rd_busy        = rd_busy_q;
  assign ready_count    = ready_cnt_q;
  assign frames_dropped = dropped_q;
  assign protocol_err   = perr_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Scoreboard bench for frame_buffer_scheduler (NUM_BUFFERS=4, stride 0x80_0000).
// Stimulus pushes expected writer updates and read grants; a monitor pops and
// compares them whenever the DUT updates wr_start_addr or pulses rd_ack.
module tb_frame_buffer_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_frame_done = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_done = 1'b0;
  logic [29:0] wr_start_addr;
  logic        rd_ack;
  logic [29:0] rd_addr;
  logic        rd_busy;
  logic [3:0]  ready_count;
  logic [15:0] frames_dropped;
  logic        protocol_err;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  rc;
    logic [15:0] drop;
  } wr_exp_t;

  typedef struct {
    logic [29:0] addr;
    int          cyc;
  } rd_exp_t;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0;

  logic [29:0] a_addr [5];
  logic [3:0]  a_rc   [5];
  logic [15:0] a_drop [5];

  frame_buffer_scheduler #(
    .NUM_BUFFERS(4),
    .BUF_BASE   (30'h0000_0000),
    .BUF_STRIDE (30'h0080_0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_frame_done (wr_frame_done),
    .wr_start_addr (wr_start_addr),
    .rd_req        (rd_req),
    .rd_ack        (rd_ack),
    .rd_addr       (rd_addr),
    .rd_done       (rd_done),
    .rd_busy       (rd_busy),
    .ready_count   (ready_count),
    .frames_dropped(frames_dropped),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst wr_start_addr",  32'(wr_start_addr),  32'h0000_0000);
    chk("rst rd_ack",         32'(rd_ack),         32'd0);
    chk("rst rd_addr",        32'(rd_addr),        32'h0000_0000);
    chk("rst rd_busy",        32'(rd_busy),        32'd0);
    chk("rst ready_count",    32'(ready_count),    32'd0);
    chk("rst frames_dropped", 32'(frames_dropped), 32'd0);
    chk("rst protocol_err",   32'(protocol_err),   32'd0);
  endtask

  task automatic push_wr(input logic [29:0] addr, input logic [3:0] rc, input logic [15:0] drop);
    wr_exp_t e;
    e.addr = addr; e.rc = rc; e.drop = drop;
    wr_q.push_back(e);
  endtask

  task automatic push_rd(input logic [29:0] addr, input int at_cyc);
    rd_exp_t e;
    e.addr = addr; e.cyc = at_cyc;
    rd_q.push_back(e);
  endtask

  // Monitor: writer update is visible the cycle after a sampled pulse; grants on rd_ack.
  initial begin : monitor
    logic    pend;
    wr_exp_t we;
    rd_exp_t re;
    forever begin
      @(posedge clk);
      pend = wr_frame_done & reset_n;
      @(negedge clk);
      if (pend) begin
        if (wr_q.size() > 0) begin
          we = wr_q.pop_front();
          chk("wr_start_addr",  32'(wr_start_addr),  32'(we.addr));
          chk("ready_count",    32'(ready_count),    32'(we.rc));
          chk("frames_dropped", 32'(frames_dropped), 32'(we.drop));
        end else begin
          chk("wr update without expectation", 32'(wr_q.size()), 32'd1);
        end
      end
      if (rd_ack) begin
        if (rd_q.size() > 0) begin
          re = rd_q.pop_front();
          chk("rd_addr",       32'(rd_addr), 32'(re.addr));
          chk("rd_ack cycle",  32'(cyc),     32'(re.cyc));
          chk("rd_busy @ack",  32'(rd_busy), 32'd1);
        end else begin
          chk("unexpected rd_ack", 32'(rd_ack), 32'd0);
        end
      end
    end
  end

  initial begin
    a_addr[0] = 30'h0080_0000; a_rc[0] = 4'd1; a_drop[0] = 16'd0;
    a_addr[1] = 30'h0100_0000; a_rc[1] = 4'd2; a_drop[1] = 16'd0;
    a_addr[2] = 30'h0180_0000; a_rc[2] = 4'd3; a_drop[2] = 16'd0;
    a_addr[3] = 30'h0000_0000; a_rc[3] = 4'd3; a_drop[3] = 16'd1;
    a_addr[4] = 30'h0080_0000; a_rc[4] = 4'd3; a_drop[4] = 16'd2;

    reset_n = 1'b0;
    tick();
    tick();
    check_reset();
    reset_n = 1'b1;
    tick();

    // Five back-to-back frames, no reader: fill then recycle buffers 0 and 1.
    for (int k = 0; k < 5; k++) begin
      push_wr(a_addr[k], a_rc[k], a_drop[k]);
      wr_frame_done = 1'b1;
      tick();
    end
    wr_frame_done = 1'b0;
    tick();

    // Grant and recycle collide on buffer 2: reader wins, writer takes buffer 3.
    push_wr(30'h0180_0000, 4'd2, 16'd3);
    push_rd(30'h0100_0000, cyc + 1);
    rd_req = 1'b1;
    wr_frame_done = 1'b1;
    tick();
    rd_req = 1'b0;
    wr_frame_done = 1'b0;
    tick();
    chk("rd_busy held", 32'(rd_busy), 32'd1);

    // Release and write completion together: writer reuses the released buffer 2.
    push_wr(30'h0100_0000, 4'd3, 16'd3);
    rd_done = 1'b1;
    wr_frame_done = 1'b1;
    tick();
    rd_done = 1'b0;
    wr_frame_done = 1'b0;
    chk("rd_busy after release", 32'(rd_busy), 32'd0);
    tick();

    // Stray rd_done sets the sticky error.
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("protocol_err set", 32'(protocol_err), 32'd1);

    push_wr(30'h0000_0000, 4'd3, 16'd4);
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    tick();
    chk("protocol_err sticky 1", 32'(protocol_err), 32'd1);

    // Read the oldest frame (buffer 1), then hold rd_req while busy: no extra ack.
    push_rd(30'h0080_0000, cyc + 1);
    rd_req = 1'b1;
    tick();
    repeat (4) tick();
    // Release with rd_req still held: next oldest (buffer 3) granted after release.
    push_rd(30'h0180_0000, cyc + 1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    rd_req = 1'b0;
    tick();
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("rd_busy after 2nd release", 32'(rd_busy), 32'd0);
    chk("ready_count after reads", 32'(ready_count), 32'd1);
    chk("protocol_err sticky 2", 32'(protocol_err), 32'd1);

    // Mid-traffic reset discards everything and clears the error; rd_req held through it.
    reset_n = 1'b0;
    rd_req = 1'b1;
    tick();
    check_reset();
    reset_n = 1'b1;
    t0 = cyc;
    while (cyc < t0 + 10) tick();

    // Frame completes at cycle 10; ack expected at cycle 12 for buffer 0.
    push_wr(30'h0080_0000, 4'd1, 16'd0);
    push_rd(30'h0000_0000, t0 + 12);
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    repeat (5) tick();

    // Another frame completes while the reader is busy: no ack.
    push_wr(30'h0100_0000, 4'd1, 16'd0);
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    repeat (4) tick();
    rd_req = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("rd_busy final release", 32'(rd_busy), 32'd0);
    repeat (3) tick();

    chk("pending wr expectations", 32'(wr_q.size()), 32'd0);
    chk("pending rd expectations", 32'(rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
